// File: rtl/load_unit_if.sv
// Data-memory read bus between load_unit (master) and memory (slave).
interface load_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/load_unit.sv
// Multi-cycle LB/LH/LW/LBU/LHU load unit: one word-aligned read, then extend and write back.
// Optional LOAD_TIMEOUT_EN aborts a read that waits TIMEOUT_CYCLES without mem_ready.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1,
  output logic        busy,
  load_unit_if.master mem,
  output logic        done,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic        misaligned,
  output logic        illegal
`ifdef LOAD_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state, state_n;
  logic [2:0]  f3_q, f3_n;
  logic [1:0]  off_q, off_n;
  logic        busy_n, mem_req_q, mem_req_n, done_n, rd_we_n, misaligned_n, illegal_n;
  logic [31:0] mem_addr_q, mem_addr_n, rd_data_n;
  logic [4:0]  rd_addr_n;

  // Decode of the incoming instruction, used only in IDLE
  logic [2:0]  f3_in;
  logic [31:0] ea_c;
  logic        valid_c, misal_c;
  logic        unused_rs1_field;

  assign f3_in   = instruction[14:12];
  assign ea_c    = rs1 + {{20{instruction[31]}}, instruction[31:20]};
  assign valid_c = (instruction[6:0] == 7'b0000011) &&
                   (f3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misal_c = ((f3_in[1:0] == 2'b01) && ea_c[0]) ||
                   ((f3_in == 3'b010) && (ea_c[1:0] != 2'b00));
  assign unused_rs1_field = ^instruction[19:15];

  // Lane extraction from the returned word
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;

  assign byte_c = 8'(mem.mem_rdata >> {off_q, 3'b000});
  assign half_c = 16'(mem.mem_rdata >> {off_q[1], 4'b0000});

  always_comb begin
    case (f3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = mem.mem_rdata;
    endcase
  end

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             timeout_n;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_n      = state;
    f3_n         = f3_q;
    off_n        = off_q;
    mem_req_n    = 1'b0;
    mem_addr_n   = mem_addr_q;
    done_n       = 1'b0;
    rd_we_n      = 1'b0;
    misaligned_n = 1'b0;
    illegal_n    = 1'b0;
    rd_addr_n    = rd_addr;
    rd_data_n    = rd_data;
`ifdef LOAD_TIMEOUT_EN
    cnt_n        = cnt_q;
    timeout_n    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          f3_n      = f3_in;
          off_n     = ea_c[1:0];
          rd_addr_n = instruction[11:7];
          if (!valid_c || misal_c) begin
            state_n      = S_RESP;
            done_n       = 1'b1;
            rd_data_n    = 32'd0;
            illegal_n    = !valid_c;
            misaligned_n = valid_c;
          end else begin
            state_n    = S_REQ;
            mem_req_n  = 1'b1;
            mem_addr_n = {ea_c[31:2], 2'b00};
`ifdef LOAD_TIMEOUT_EN
            cnt_n      = '0;
`endif
          end
        end
      end
      S_REQ: begin
        mem_req_n = 1'b1;
        if (mem.mem_ready) begin
          state_n   = S_RESP;
          mem_req_n = 1'b0;
          done_n    = 1'b1;
          rd_we_n   = (rd_addr != 5'd0);
          rd_data_n = load_c;
        end
`ifdef LOAD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort: report completion with no write-back
          state_n   = S_RESP;
          mem_req_n = 1'b0;
          done_n    = 1'b1;
          rd_data_n = 32'd0;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      busy       <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      done       <= 1'b0;
      rd_we      <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      rd_addr    <= 5'd0;
      rd_data    <= 32'd0;
`ifdef LOAD_TIMEOUT_EN
      cnt_q      <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      f3_q       <= f3_n;
      off_q      <= off_n;
      busy       <= busy_n;
      mem_req_q  <= mem_req_n;
      mem_addr_q <= mem_addr_n;
      done       <= done_n;
      rd_we      <= rd_we_n;
      misaligned <= misaligned_n;
      illegal    <= illegal_n;
      rd_addr    <= rd_addr_n;
      rd_data    <= rd_data_n;
`ifdef LOAD_TIMEOUT_EN
      cnt_q      <= cnt_n;
      timeout    <= timeout_n;
`endif
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_load_unit.sv
// Randomized self-checking bench for load_unit against an arithmetic reference model.
module tb_load_unit;

  localparam int unsigned TO_CYCLES = 15;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] instruction, rs1;
  logic        busy, done, rd_we, misaligned, illegal;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
`ifdef LOAD_TIMEOUT_EN
  logic        timeout;
`endif

  load_unit_if bus();

  load_unit #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instruction (instruction),
    .rs1         (rs1),
    .busy        (busy),
    .mem         (bus),
    .done        (done),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_we       (rd_we),
    .misaligned  (misaligned),
    .illegal     (illegal)
`ifdef LOAD_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rsf,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rsf, f3, rd, 7'b0000011};
  endfunction

  // Reference result: shift the selected lane down, mask, then subtract 2^n when signed and negative
  function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [31:0] ea,
                                             input logic [31:0] word);
    int unsigned k;
    logic [31:0] v;
    k = 32'(ea[1:0]);
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * k)) & 32'h0000_00FF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * (k / 2))) & 32'h0000_FFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic do_load(input logic [31:0] ins, input logic [31:0] base,
                         input logic [31:0] word, input int waits, input bit junk);
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] ea;
    bit legal, mis, fault;
    int lat, req, exp_lat, exp_req;
    f3    = ins[14:12];
    rd    = ins[11:7];
    ea    = base + 32'($signed(ins[31:20]));
    legal = (ins[6:0] == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = legal && ((((f3 == 3'd1) || (f3 == 3'd5)) && ea[0]) ||
                      ((f3 == 3'd2) && (ea[1:0] != 2'b00)));
    fault   = !legal || mis;
    exp_lat = fault ? 1 : 2 + waits;
    exp_req = fault ? 0 : waits + 1;

    instruction = ins;
    rs1         = base;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    instruction = $urandom;
    rs1         = $urandom;
    lat = 1;
    req = 0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("mem_req_first", 32'(bus.mem_req), 32'(!fault));
    while (done !== 1'b1 && lat < 60) begin
      if (bus.mem_req === 1'b1) begin
        check("mem_addr", bus.mem_addr, {ea[31:2], 2'b00});
        bus.mem_ready = (req == waits);
        bus.mem_rdata = bus.mem_ready ? word : $urandom;
        req++;
      end
      if (junk && lat == 1) begin
        start       = 1'b1;
        instruction = enc(12'h004, 5'd2, 3'd2, 5'd9);
      end
      @(posedge clk); #1;
      start         = 1'b0;
      bus.mem_ready = 1'b0;
      lat++;
    end
    check("done", 32'(done), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("req_cycles", 32'(req), 32'(exp_req));
    check("rd_addr", 32'(rd_addr), 32'(rd));
    check("rd_data", rd_data, fault ? 32'd0 : model_data(f3, ea, word));
    check("rd_we", 32'(rd_we), 32'(!fault && rd != 5'd0));
    check("misaligned", 32'(misaligned), 32'(mis));
    check("illegal", 32'(illegal), 32'(!legal));
`ifdef LOAD_TIMEOUT_EN
    check("timeout_clear", 32'(timeout), 32'd0);
`endif
    // A start in the RESP cycle must be dropped
    if (junk) begin
      start       = 1'b1;
      instruction = enc(12'h008, 5'd1, 3'd2, 5'd5);
      rs1         = 32'h100;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [14] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2,
                                3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};
    logic [31:0] ins;
    int lat;

    rst = 1'b1; start = 1'b0; instruction = 32'd0; rs1 = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_rd_we", 32'(rd_we), 32'd0);
    check("rst_flags", 32'({misaligned, illegal}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_load(enc(12'd8, 5'd1, 3'd2, 5'd5), 32'h100, 32'hDEADBEEF, 0, 1'b0);
    do_load(enc(12'd3, 5'd0, 3'd0, 5'd3), 32'h0, 32'h80FF1234, 0, 1'b0);
    do_load(enc(12'd3, 5'd0, 3'd4, 5'd3), 32'h0, 32'h80FF1234, 0, 1'b0);
    do_load(enc(12'd2, 5'd4, 3'd5, 5'd7), 32'h200, 32'hBEEF0001, 3, 1'b0);
    do_load(enc(12'd1, 5'd1, 3'd2, 5'd6), 32'h100, 32'h12345678, 0, 1'b0);
    do_load(enc(12'd0, 5'd1, 3'd3, 5'd6), 32'h100, 32'h12345678, 0, 1'b0);
    do_load(enc(12'd4, 5'd1, 3'd2, 5'd0), 32'h100, 32'hCAFEF00D, 1, 1'b0);
    do_load(enc(12'hFFE, 5'd1, 3'd1, 5'd8), 32'h104, 32'h8001_7FFF, 2, 1'b1);
    do_load(32'h0000_0013, 32'h40, 32'h1, 0, 1'b1);

    // Randomized loads
    for (int i = 0; i < 150; i++) begin
      ins = {12'($urandom), 5'($urandom), f3_tab[$urandom_range(0, 13)], 5'($urandom), 7'b0000011};
      if ($urandom_range(0, 11) == 0) ins[6:0] = 7'($urandom);
      do_load(ins, $urandom, $urandom, $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
    end

    // Reset two cycles into REQ drops the request silently
    instruction = enc(12'd0, 5'd1, 3'd2, 5'd4);
    rs1   = 32'h40;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_req_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_req_busy", 32'(busy), 32'd0);
    check("rst_req_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_req_no_done", 32'(done), 32'd0);
    end

`ifdef LOAD_TIMEOUT_EN
    // mem_ready never arrives
    instruction = enc(12'd8, 5'd1, 3'd2, 5'd5);
    rs1   = 32'h100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("to_latency", 32'(lat), 32'(1 + TO_CYCLES));
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_rd_we", 32'(rd_we), 32'd0);
    check("to_rd_data", rd_data, 32'd0);
    check("to_mem_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    check("to_idle", 32'(busy), 32'd0);
`else
    lat = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Multi-cycle I-type load unit; the read-side counterpart of the store datapath.
- Decodes LB/LH/LW/LBU/LHU and computes the effective address rs1 + sign-extended imm[11:0].
- Issues one word-aligned read to data memory over a req/ready handshake.
- Extracts, sign- or zero-extends and returns the result with a register-file write strobe.

Parameters:
- TIMEOUT_CYCLES, 15, max cycles spent in REQ before abort (used only with LOAD_TIMEOUT_EN).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to execute `instruction`; honoured only when busy=0.
- instruction  input  32  complete load instruction.
- rs1  input  32  base address register value.
- busy  output  1  high in any state except IDLE.
- mem_req  output  1  read request to data memory.
- mem_addr  output  32  word-aligned read address, {ea[31:2],2'b00}.
- mem_ready  input  1  memory accepts request and mem_rdata is valid in the same cycle.
- mem_rdata  input  32  read word, little-endian byte lanes.
- done  output  1  one-cycle completion pulse.
- rd_addr  output  5  destination register, instruction[11:7].
- rd_data  output  32  extended load result.
- rd_we  output  1  register write strobe, coincident with done.
- misaligned  output  1  fault flag, valid with done.
- illegal  output  1  fault flag, valid with done.

Behaviour:
- Reset: state=IDLE; busy, mem_req, done, rd_we, misaligned, illegal = 0; mem_addr, rd_data = 0; rd_addr = 0. Reset takes effect at the next edge from any state; an outstanding request is dropped with no done.
- States: IDLE, REQ, RESP.
- IDLE:
  - When start=1, capture funct3, rd, ea = rs1 + {{20{instruction[31]}}, instruction[31:20]} (mod 2^32), and byte offset ea[1:0].
  - Valid iff opcode (instruction[6:0]) == 7'b0000011 and funct3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}. Otherwise go to RESP with illegal=1.
  - Misaligned iff (LH/LHU and ea[0]=1) or (LW and ea[1:0]≠0). Go to RESP with misaligned=1; no memory request.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1 and mem_addr held stable.
  - When mem_ready=1, latch mem_rdata, go to RESP, and deassert mem_req at the next cycle.
- RESP: one cycle; done=1, rd_addr=rd, then return to IDLE.
  - rd_we=1 only if no fault and rd≠0.
  - rd_data=0 on fault.
- Extraction, k = ea[1:0]:
  - LB/LBU: byte = rdata[8k+7:8k]; sign- or zero-extend.
  - LH/LHU: half = rdata[16·ea[1]+15:16·ea[1]]; sign- or zero-extend.
  - LW: full word.
- Latency: start at cycle N, mem_ready=1 at N+1 gives done at N+2 (minimum). Each wait cycle adds 1. Fault path: done at N+1.
- Start while busy is ignored with no side effects. Start arriving in the same cycle as RESP is ignored; a new start is accepted from the following IDLE cycle.
- done, rd_we, misaligned and illegal are registered and high only in RESP.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- Defined: a counter cleared on REQ entry increments each REQ cycle with mem_ready=0. When it reaches TIMEOUT_CYCLES, go to RESP with done=1, rd_we=0, rd_data=0, and extra output port timeout=1. mem_req drops at that edge.
- Undefined: no counter and no timeout port; REQ waits indefinitely.

Test Plan:
- LW x5, 8(x1), rs1=0x100, mem_ready immediate, rdata=0xDEADBEEF -> mem_addr=0x108, done at start+2, rd_addr=5, rd_data=0xDEADBEEF, rd_we=1.
- LB x3, 3(x0), rs1=0x0, rdata=0x80FF1234 -> mem_addr=0x0, rd_data=0xFFFFFF80. Same with LBU -> 0x00000080.
- LHU rd=7, imm=2, rs1=0x200, rdata=0xBEEF0001, mem_ready delayed 3 cycles -> mem_req held 4 cycles, rd_data=0x0000BEEF, done at start+5.
- LW imm=1, rs1=0x100 -> no mem_req, done at start+1, misaligned=1, rd_we=0. funct3=011 -> illegal=1, rd_we=0.
- LW to rd=0 -> done=1, rd_we=0. Second start while busy -> ignored, only one done.
- rst=1 two cycles into REQ -> mem_req=0 and busy=0 after the edge, no done. With LOAD_TIMEOUT_EN and mem_ready held 0 -> timeout=1, done at start+1+TIMEOUT_CYCLES.
